// File: rtl/frb_framer_pkg.sv
// Shared types and record layout for the FRB candidate framer.
// The 128-bit record is assembled here so the field map lives in one place.
package frb_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MERGE   = 2'd1,
    ST_EMIT    = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

  localparam int SEQ_W   = 16;
  localparam int WIDTH_W = 16;

  localparam int REC_W         = 128;
  localparam int REC_TS_LSB    = 80;
  localparam int REC_TS_W      = 48;
  localparam int REC_DM_LSB    = 64;
  localparam int REC_DM_W      = 16;
  localparam int REC_SNR_LSB   = 32;
  localparam int REC_SNR_W     = 32;
  localparam int REC_WIDTH_LSB = 16;
  localparam int REC_SEQ_LSB   = 0;

  function automatic logic [REC_W-1:0] pack_record(
    input logic [REC_TS_W-1:0]  ts,
    input logic [REC_DM_W-1:0]  dm,
    input logic [REC_SNR_W-1:0] snr,
    input logic [WIDTH_W-1:0]   width,
    input logic [SEQ_W-1:0]     seq
  );
    logic [REC_W-1:0] rec;
    rec = {REC_W{1'b0}};
    rec[REC_TS_LSB    +: REC_TS_W]  = ts;
    rec[REC_DM_LSB    +: REC_DM_W]  = dm;
    rec[REC_SNR_LSB   +: REC_SNR_W] = snr;
    rec[REC_WIDTH_LSB +: WIDTH_W]   = width;
    rec[REC_SEQ_LSB   +: SEQ_W]     = seq;
    return rec;
  endfunction

endpackage

// File: rtl/frb_ts_counter.sv
// Sample timestamp counter: counts sample_valid pulses, re-zeroed by sync.
// A sample coincident with sync is stamped 0 and the following one 1.
module frb_ts_counter #(
  parameter int TS_W = 48
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ce_i,
  input  logic            sync_i,
  input  logic            sample_valid_i,
  output logic [TS_W-1:0] stamp_o
);

  logic [TS_W-1:0] ts_q, ts_d;

  assign stamp_o = sync_i ? {TS_W{1'b0}} : ts_q;

  // Next timestamp; frozen while the clock enable is low
  always_comb begin
    ts_d = ts_q;
    if (ce_i) begin
      ts_d = stamp_o + TS_W'(sample_valid_i);
    end else begin
      ts_d = ts_q;
    end
  end

  // Timestamp register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ts_q <= {TS_W{1'b0}};
    end else begin
      ts_q <= ts_d;
    end
  end

endmodule

// File: rtl/frb_candidate_framer.sv
// Merges bursts of qualifying detector samples into single time-stamped
// candidates and emits one 128-bit record per candidate, dropping on fifo_full.
module frb_candidate_framer
  import frb_framer_pkg::*;
#(
  parameter int DM_W = 10,
  parameter int TS_W = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              sync_in,
  input  logic              sample_valid,
  input  logic              cand_valid,
  input  logic [DM_W-1:0]   cand_dm,
  input  logic [31:0]       cand_snr,
  input  logic [31:0]       threshold,
  input  logic [15:0]       merge_len,
  input  logic [15:0]       holdoff_len,
  input  logic              fifo_full,
  output logic [REC_W-1:0]  dout,
  output logic              dout_valid,
  output logic [31:0]       cand_count,
  output logic [31:0]       drop_count
);

  state_e             state_q, state_d;
  logic [TS_W-1:0]    stamp;
  logic [TS_W-1:0]    pk_ts_q, pk_ts_d;
  logic [DM_W-1:0]    pk_dm_q, pk_dm_d;
  logic [31:0]        pk_snr_q, pk_snr_d;
  logic [WIDTH_W-1:0] width_q, width_d, width_inc;
  logic [15:0]        win_cnt_q, win_cnt_d, win_inc;
  logic [15:0]        win_len_q, win_len_d;
  logic [15:0]        hold_cnt_q, hold_cnt_d, hold_inc;
  logic [15:0]        hold_len_q, hold_len_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [31:0]        cand_cnt_q, cand_cnt_d;
  logic [31:0]        drop_cnt_q, drop_cnt_d;
  logic [REC_W-1:0]   dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               qualify;

  frb_ts_counter #(
    .TS_W (TS_W)
  ) u_ts (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .ce_i           (ce),
    .sync_i         (sync_in),
    .sample_valid_i (sample_valid),
    .stamp_o        (stamp)
  );

  assign qualify   = sample_valid & cand_valid & (cand_snr >= threshold);
  assign win_inc   = win_cnt_q + 16'd1;
  assign hold_inc  = hold_cnt_q + 16'd1;
  assign width_inc = (width_q == {WIDTH_W{1'b1}}) ? width_q : width_q + 16'd1;

  // Next-state and datapath updates; everything holds while ce is low
  always_comb begin
    state_d      = state_q;
    pk_ts_d      = pk_ts_q;
    pk_dm_d      = pk_dm_q;
    pk_snr_d     = pk_snr_q;
    width_d      = width_q;
    win_cnt_d    = win_cnt_q;
    win_len_d    = win_len_q;
    hold_cnt_d   = hold_cnt_q;
    hold_len_d   = hold_len_q;
    seq_d        = seq_q;
    cand_cnt_d   = cand_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (ce) begin
      dout_valid_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (qualify) begin
            pk_ts_d   = stamp;
            pk_dm_d   = cand_dm;
            pk_snr_d  = cand_snr;
            width_d   = 16'd1;
            win_cnt_d = 16'd1;
            win_len_d = merge_len;
            state_d   = (merge_len <= 16'd1) ? ST_EMIT : ST_MERGE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MERGE: begin
          if (sample_valid) begin
            win_cnt_d = win_inc;
            // Strict compare: on equal S/N the earliest sample stays the peak
            if (qualify) begin
              width_d = width_inc;
              if (cand_snr > pk_snr_q) begin
                pk_ts_d  = stamp;
                pk_dm_d  = cand_dm;
                pk_snr_d = cand_snr;
              end else begin
                pk_snr_d = pk_snr_q;
              end
            end else begin
              width_d = width_q;
            end
            state_d = (win_inc == win_len_q) ? ST_EMIT : ST_MERGE;
          end else begin
            state_d = ST_MERGE;
          end
        end
        ST_EMIT: begin
          cand_cnt_d = cand_cnt_q + 32'd1;
          if (!fifo_full) begin
            dout_d       = pack_record(REC_TS_W'(pk_ts_q), REC_DM_W'(pk_dm_q),
                                       pk_snr_q, width_q, seq_q);
            dout_valid_d = 1'b1;
            seq_d        = seq_q + 16'd1;
          end else begin
            drop_cnt_d = drop_cnt_q + 32'd1;
          end
          hold_len_d = holdoff_len;
          hold_cnt_d = 16'(sample_valid);
          if (holdoff_len == 16'd0) begin
            state_d = ST_IDLE;
          end else if (sample_valid && (holdoff_len == 16'd1)) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (sample_valid) begin
            hold_cnt_d = hold_inc;
            state_d    = (hold_inc == hold_len_q) ? ST_IDLE : ST_HOLDOFF;
          end else begin
            state_d = ST_HOLDOFF;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      dout_valid_d = dout_valid_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pk_ts_q      <= {TS_W{1'b0}};
      pk_dm_q      <= {DM_W{1'b0}};
      pk_snr_q     <= 32'd0;
      width_q      <= 16'd0;
      win_cnt_q    <= 16'd0;
      win_len_q    <= 16'd0;
      hold_cnt_q   <= 16'd0;
      hold_len_q   <= 16'd0;
      seq_q        <= 16'd0;
      cand_cnt_q   <= 32'd0;
      drop_cnt_q   <= 32'd0;
      dout_q       <= 128'd0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pk_ts_q      <= pk_ts_d;
      pk_dm_q      <= pk_dm_d;
      pk_snr_q     <= pk_snr_d;
      width_q      <= width_d;
      win_cnt_q    <= win_cnt_d;
      win_len_q    <= win_len_d;
      hold_cnt_q   <= hold_cnt_d;
      hold_len_q   <= hold_len_d;
      seq_q        <= seq_d;
      cand_cnt_q   <= cand_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // A disabled cycle does not exist to the block, so no strobe is shown in it
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q & ce;
  assign cand_count = cand_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_frb_candidate_framer.sv
// Bench for frb_candidate_framer: directed table, hand-written corner
// sequences and randomized traffic against a sample-level reference model.
module tb_frb_candidate_framer;

  logic         clk = 1'b0;
  logic         rst_n, ce, sync_in, sample_valid, cand_valid, fifo_full;
  logic [9:0]   cand_dm;
  logic [31:0]  cand_snr, threshold;
  logic [15:0]  merge_len, holdoff_len;
  logic [127:0] dout;
  logic         dout_valid;
  logic [31:0]  cand_count, drop_count;

  always #5 clk = ~clk;

  frb_candidate_framer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce           (ce),
    .sync_in      (sync_in),
    .sample_valid (sample_valid),
    .cand_valid   (cand_valid),
    .cand_dm      (cand_dm),
    .cand_snr     (cand_snr),
    .threshold    (threshold),
    .merge_len    (merge_len),
    .holdoff_len  (holdoff_len),
    .fifo_full    (fifo_full),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .cand_count   (cand_count),
    .drop_count   (drop_count)
  );

  int           n_chk = 0, n_fail = 0;
  int           step_cnt = 0, n_valid = 0, last_step = 0;
  logic [127:0] last_rec = 128'd0;
  bit           chk_en = 1'b0;

  // Reference model: window/holdoff tracked as "samples remaining" counts
  logic [47:0]  m_ts, m_pk_ts;
  logic [31:0]  m_pk_snr, m_cand, m_drop;
  int           m_pk_dm, m_width, m_remain, m_hold;
  logic [15:0]  m_seq;
  bit           m_inwin, m_emit, m_valid;
  logic [127:0] m_dout;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, step_cnt);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (step %0d)", name, act, exp, step_cnt);
    end
  endtask

  function automatic logic [127:0] mk_rec(input logic [47:0] ts, input int dm,
                                          input logic [31:0] snr, input int width, input int seq);
    return {ts, 16'(dm), snr, 16'(width), 16'(seq)};
  endfunction

  task automatic model_update();
    logic [47:0] stamp;
    bit q;
    if (!rst_n) begin
      m_ts = 48'd0; m_pk_ts = 48'd0; m_pk_snr = 32'd0; m_cand = 32'd0; m_drop = 32'd0;
      m_pk_dm = 0; m_width = 0; m_remain = 0; m_hold = 0; m_seq = 16'd0;
      m_inwin = 1'b0; m_emit = 1'b0; m_valid = 1'b0; m_dout = 128'd0;
      return;
    end
    if (!ce) return;
    stamp   = sync_in ? 48'd0 : m_ts;
    q       = sample_valid && cand_valid && (cand_snr >= threshold);
    m_valid = 1'b0;
    if (m_emit) begin
      m_emit = 1'b0;
      m_cand++;
      if (!fifo_full) begin
        m_dout  = mk_rec(m_pk_ts, m_pk_dm, m_pk_snr, m_width, int'(m_seq));
        m_valid = 1'b1;
        m_seq++;
      end else begin
        m_drop++;
      end
      m_hold = (holdoff_len == 16'd0) ? 0 : int'(holdoff_len) - int'(sample_valid);
    end else if (m_hold > 0) begin
      if (sample_valid) m_hold--;
    end else if (m_inwin) begin
      if (sample_valid) begin
        m_remain--;
        if (q) begin
          if (m_width < 65535) m_width++;
          if (cand_snr > m_pk_snr) begin
            m_pk_ts = stamp; m_pk_dm = int'(cand_dm); m_pk_snr = cand_snr;
          end
        end
        if (m_remain == 0) begin
          m_inwin = 1'b0;
          m_emit  = 1'b1;
        end
      end
    end else if (q) begin
      m_pk_ts = stamp; m_pk_dm = int'(cand_dm); m_pk_snr = cand_snr; m_width = 1;
      if (merge_len <= 16'd1) m_emit = 1'b1;
      else begin
        m_inwin  = 1'b1;
        m_remain = int'(merge_len) - 1;
      end
    end
    m_ts = stamp + 48'(sample_valid);
  endtask

  // One clock cycle with the currently driven inputs
  task automatic step();
    @(negedge clk);
    if (chk_en) begin
      chk_i("dout_valid", int'(dout_valid), int'(m_valid & ce));
      chk("dout", dout, m_dout);
      chk_i("cand_count", int'(cand_count), int'(m_cand));
      chk_i("drop_count", int'(drop_count), int'(m_drop));
    end
    if (dout_valid === 1'b1) begin
      n_valid++;
      last_rec  = dout;
      last_step = step_cnt;
    end
    model_update();
    step_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    sample_valid = 1'b1; cand_valid = 1'b0; sync_in = 1'b0; cand_snr = 32'd0; cand_dm = 10'd0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic samp(input int snr, input int dm, input bit sync);
    sample_valid = 1'b1; cand_valid = 1'b1; sync_in = sync;
    cand_snr = 32'(snr); cand_dm = 10'(dm);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fill(1);
    rst_n = 1'b1;
    n_valid = 0;
  endtask

  typedef struct {
    int base; int ml; int hl;
    int snr [4]; int dm [4];
    bit ff; bit exp_emit;
    int exp_off; int exp_dm; int exp_snr; int exp_width; int exp_close;
  } vec_t;
  vec_t vt [6];

  initial begin
    vt[0] = '{10, 4, 0, '{150, 0, 0, 0},     '{37, 0, 0, 0},   1'b0, 1'b1, 0, 37,   150, 1, 3};
    vt[1] = '{20, 8, 0, '{120, 300, 300, 90}, '{5, 9, 11, 3},  1'b0, 1'b1, 1, 9,    300, 3, 7};
    vt[2] = '{5,  1, 0, '{200, 0, 0, 0},     '{7, 0, 0, 0},    1'b0, 1'b1, 0, 7,    200, 1, 0};
    vt[3] = '{5,  0, 0, '{180, 0, 0, 0},     '{1023, 0, 0, 0}, 1'b0, 1'b1, 0, 1023, 180, 1, 0};
    vt[4] = '{30, 3, 0, '{100, 99, 101, 500}, '{2, 3, 4, 6},   1'b0, 1'b1, 2, 4,    101, 2, 2};
    vt[5] = '{7,  2, 0, '{130, 140, 0, 0},   '{1, 2, 0, 0},    1'b1, 1'b0, 0, 0,    0,   0, 1};

    rst_n = 1'b0; ce = 1'b1; sync_in = 1'b0; sample_valid = 1'b0; cand_valid = 1'b0;
    fifo_full = 1'b0; cand_dm = 10'd0; cand_snr = 32'd0; threshold = 32'd100;
    merge_len = 16'd4; holdoff_len = 16'd0;
    step();
    step();
    chk_en = 1'b1;
    chk("reset_dout", dout, 128'd0);
    chk_i("reset_dout_valid", int'(dout_valid), 0);
    chk_i("reset_cand_count", int'(cand_count), 0);
    chk_i("reset_drop_count", int'(drop_count), 0);
    rst_n = 1'b1;

    // Directed table: one window per row, started at a known timestamp
    for (int r = 0; r < 6; r++) begin
      int s0;
      do_reset();
      threshold = 32'd100; merge_len = 16'(vt[r].ml); holdoff_len = 16'(vt[r].hl);
      fifo_full = vt[r].ff;
      fill(vt[r].base);
      n_valid = 0;
      s0 = step_cnt;
      for (int k = 0; k < 4; k++) samp(vt[r].snr[k], vt[r].dm[k], 1'b0);
      fill(12);
      chk_i("row_n_valid", n_valid, int'(vt[r].exp_emit));
      if (vt[r].exp_emit) begin
        chk("row_record", last_rec, mk_rec(48'(vt[r].base + vt[r].exp_off), vt[r].exp_dm,
                                           32'(vt[r].exp_snr), vt[r].exp_width, 0));
        chk_i("row_latency", last_step, s0 + vt[r].exp_close + 2);
      end
      chk_i("row_cand_count", int'(cand_count), 1);
      chk_i("row_drop_count", int'(drop_count), int'(vt[r].ff));
      fifo_full = 1'b0;
    end

    // Holdoff: candidate 3 samples after EMIT ignored, one 8 samples after emitted
    do_reset();
    merge_len = 16'd1; holdoff_len = 16'd5;
    samp(150, 1, 1'b0); fill(3); samp(222, 2, 1'b0); fill(4); samp(333, 3, 1'b0); fill(5);
    chk_i("holdoff_n_valid", n_valid, 2);
    chk("holdoff_second", last_rec, mk_rec(48'd9, 3, 32'd333, 1, 1));

    // Drop on fifo_full during EMIT, then the next record still carries seq 0
    do_reset();
    merge_len = 16'd1; holdoff_len = 16'd0;
    samp(150, 4, 1'b0);
    fifo_full = 1'b1; fill(1);
    fifo_full = 1'b0; fill(1);
    samp(160, 5, 1'b0); fill(3);
    chk_i("drop_drop_count", int'(drop_count), 1);
    chk_i("drop_cand_count", int'(cand_count), 2);
    chk_i("drop_n_valid", n_valid, 1);
    chk("drop_next_record", last_rec, mk_rec(48'd3, 5, 32'd160, 1, 0));

    // Sync coincident with a qualifying sample at ts=500
    do_reset();
    merge_len = 16'd2; holdoff_len = 16'd0;
    fill(500);
    samp(200, 8, 1'b1); samp(300, 9, 1'b0); fill(3);
    chk("sync_next_stamp", last_rec, mk_rec(48'd1, 9, 32'd300, 2, 0));
    merge_len = 16'd1;
    samp(210, 6, 1'b1); fill(3);
    chk("sync_zero_stamp", last_rec, mk_rec(48'd0, 6, 32'd210, 1, 1));

    // Reset pulse in the middle of a merge window
    do_reset();
    merge_len = 16'd8; holdoff_len = 16'd0;
    samp(150, 1, 1'b0); samp(170, 2, 1'b0);
    rst_n = 1'b0; fill(1); rst_n = 1'b1;
    fill(12);
    chk_i("rst_n_valid", n_valid, 0);
    chk_i("rst_cand_count", int'(cand_count), 0);
    chk_i("rst_drop_count", int'(drop_count), 0);
    chk("rst_dout", dout, 128'd0);
    merge_len = 16'd1;
    samp(180, 3, 1'b0); fill(3);
    chk("rst_fresh_record", last_rec, mk_rec(48'd12, 3, 32'd180, 1, 0));

    // Randomized traffic, checked every cycle against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      ce           = ($urandom_range(0, 9) != 0);
      sync_in      = ($urandom_range(0, 49) == 0);
      sample_valid = ($urandom_range(0, 3) != 0);
      cand_valid   = ($urandom_range(0, 9) < 6);
      cand_dm      = 10'($urandom_range(0, 1023));
      cand_snr     = 32'($urandom_range(0, 255));
      threshold    = 32'($urandom_range(50, 150));
      merge_len    = 16'($urandom_range(0, 5));
      holdoff_len  = 16'($urandom_range(0, 6));
      fifo_full    = ($urandom_range(0, 3) == 0);
      step();
    end
    rst_n = 1'b1; ce = 1'b1;
    fill(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frb_candidate_framer.md
# frb_candidate_framer

Upstream feeder of the 10GbE packetizer. Takes the per-sample trigger stream from the FRB detection stage and merges bursts of above-threshold samples into single candidates. Each candidate is time-stamped with a sample counter and emitted as one 128-bit record on `dout`/`dout_valid`, which drive the packetizer's `din`/`din_valid`. When the packetizer FIFO is full, records are dropped and counted; the block does not stall.

## Interface
- `DM_W`, 10: width of DM index input.
- `TS_W`, 48: timestamp width; must be ≤48.
- `clk` in 1: single clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `ce` in 1: clock enable; when low, all state is frozen and `dout_valid` is 0.
- `sync_in` in 1: timestamp re-zero strobe.
- `sample_valid` in 1: one pulse per time sample.
- `cand_valid` in 1: detector flag for this sample; ignored unless `sample_valid`.
- `cand_dm` in DM_W: DM index of this sample's peak.
- `cand_snr` in 32: unsigned S/N of this sample.
- `threshold` in 32: acceptance level; a sample qualifies iff `sample_valid & cand_valid & cand_snr >= threshold`. Sampled live.
- `merge_len` in 16: merge window length, in samples.
- `holdoff_len` in 16: dead time after emission, in samples.
- `fifo_full` in 1: packetizer FIFO full.
- `dout` out 128: candidate record.
- `dout_valid` out 1: one-cycle record strobe.
- `cand_count` out 32: count of closed candidates, whether emitted or dropped; wraps.
- `drop_count` out 32: count of records dropped on `fifo_full`; wraps.

## Operation
- **Record layout:**
  - [127:80] = peak timestamp, zero-extended to 48 bits.
  - [79:64] = peak DM, zero-extended.
  - [63:32] = peak S/N.
  - [31:16] = width (qualifying samples in the window), saturates at 0xFFFF.
  - [15:0] = seq, which increments only on emitted records and wraps.
- **Timestamp:**
  - `stamp = sync_in ? 0 : ts`.
  - `ts <= stamp + sample_valid`, mod 2^TS_W.
  - A sample coincident with `sync_in` is stamped 0.
- **FSM: IDLE, MERGE, EMIT, HOLDOFF.**
- **IDLE:**
  - On a qualifying sample: load peak as {stamp, dm, snr}, set width=1, set win_cnt=1, and latch `merge_len`.
  - Then go to EMIT if the latched `merge_len ≤ 1`; otherwise go to MERGE.
- **MERGE:**
  - On each `sample_valid`, increment win_cnt.
  - On a qualifying sample, increment width (saturating).
  - Replace the peak only if `cand_snr > peak_snr` (strict), so ties keep the earliest sample.
  - When the updated win_cnt equals the latched length, go to EMIT.
- **EMIT:** lasts exactly one cycle.
  - Increment `cand_count`.
  - If `fifo_full` is low: load `dout`, assert `dout_valid` next cycle, and increment seq.
  - Otherwise: increment `drop_count`; `dout_valid` stays low and seq is unchanged.
  - Latch `holdoff_len`.
  - Go to IDLE if it is 0; otherwise go to HOLDOFF with hold_cnt = (sample_valid this cycle ? 1 : 0).
- **HOLDOFF:**
  - Count `sample_valid`; candidates are ignored.
  - When hold_cnt reaches the latched length, go to IDLE.
  - If the EMIT-cycle sample already satisfies a length of 1, go directly to IDLE.
- **Candidate in EMIT cycle:** always discarded, even with `holdoff_len = 0`.
- **`rst_n` low, including mid-operation:**
  - State returns to IDLE; any pending candidate is discarded.
  - `ts`, seq, `cand_count`, `drop_count`, and win/hold counters are cleared.
  - `dout` = 0 and `dout_valid` = 0.

## Timing
- Reset values of all outputs are 0.
- **Latency:** the closing sample is in cycle N, EMIT is cycle N+1, and `dout_valid` is high in cycle N+2 for one cycle.
- `fifo_full` is sampled in cycle N+1 only.
- `dout` holds its value until the next emission.
- With `ce` low in a cycle, that cycle does not exist to the block; inputs are ignored.
- **Maximum record rate:** one per 2 cycles (merge_len=1, holdoff_len=0, back-to-back samples).

## Structure
- **Package `frb_framer_pkg`:**
  - State enum.
  - Record field offsets/widths.
  - `SEQ_W=16` and `WIDTH_W=16`.
- **Sub-module `frb_ts_counter`:** `sync_in`/`sample_valid` → `stamp`, `ts`. Everything else goes in one FSM module.

## Test plan
- **Single candidate.** Setup: threshold=100, merge_len=4, holdoff=0; snr=150 dm=37 at ts=10; samples continuous. Expect: one record {ts 10, dm 37, snr 150, width 1, seq 0}, 2 cycles after the ts=13 sample; `cand_count`=1.
- **Peak merge / tie.** Setup: merge_len=8; samples 120@20 dm5, 300@21 dm9, 300@22 dm11, 90@23. Expect: one record {ts 21, dm 9, snr 300, width 3}.
- **Holdoff.** Setup: holdoff_len=5; a candidate 3 samples after EMIT, then another 8 samples after. Expect: first is ignored; second is emitted with seq 1.
- **Drop.** Setup: `fifo_full` high in the EMIT cycle. Expect: no `dout_valid`, `drop_count`=1; next emitted record has seq 0.
- **Sync.** Setup: `sync_in` coincident with a qualifying sample at ts=500. Expect: record timestamp 0; the next sample is stamped 1.
- **Reset mid-MERGE.** Setup: `rst_n` low for 1 cycle during a window. Expect: no record; counters 0; a fresh candidate afterwards gets seq 0.
